btn_event_ctrl: RTL and testbench

Multi-button input controller that debounces `NUM_BTN` raw push-button inputs using one shared sample-tick timebase instead of a free-running counter per button. It classifies each button's activity into PRESS, RELEASE and LONG events and arbitrates them round-robin onto a single valid/ready event stream. It sits between the board button pins and any consumer of user-input events, such as register-control or mode FSMs.

---
 rtl/btn_event_pkg.sv | 25 ++
 rtl/btn_channel.sv | 160 ++++++++++++++++
 rtl/btn_event_ctrl.sv | 97 +++++++++
 tb/tb_btn_event_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared types for the button event controller: event codes, per-channel
// debounce states and a width helper for parameter-derived buses.
package btn_event_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2,
        LONG    = 2'd3
    } evt_type_t;

    typedef enum logic [2:0] {
        IDLE_UP,
        DEB_DOWN,
        HELD,
        LONG_HELD,
        DEB_UP
    } btn_state_t;

    // Index width that never collapses to zero bits for single-entry sets.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, tick-sampled debounce/long-press
// FSM and a one-deep pending event slot with sticky overflow.
module btn_channel
    import btn_event_pkg::*;
#(
    parameter int STABLE_TICKS = 10,
    parameter int LONG_TICKS   = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       tick,
    input  logic       drain,
    input  logic       ovf_clr,
    output logic       pend_vld,
    output logic [1:0] pend_type,
    output logic       level,
    output logic       ovf
);

    localparam int CW = $clog2(LONG_TICKS + 1);

    logic          sync1, sync2;
    btn_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          long_fired, long_fired_nxt;
    logic          emit, ovf_set;
    evt_type_t     emit_type, pend_type_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign cnt_inc = (cnt == CW'(LONG_TICKS)) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        long_fired_nxt = long_fired;
        emit           = 1'b0;
        emit_type      = NONE;
        if (tick) begin
            case (state)
                IDLE_UP: if (sync2) begin
                    if (STABLE_TICKS == 1) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        emit      = 1'b1;
                        emit_type = PRESS;
                    end else begin
                        state_nxt = DEB_DOWN;
                        cnt_nxt   = CW'(1);
                    end
                end
                DEB_DOWN: begin
                    if (!sync2) begin
                        state_nxt = IDLE_UP;
                        cnt_nxt   = '0;
                    end else if (cnt_inc >= CW'(STABLE_TICKS)) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        emit      = 1'b1;
                        emit_type = PRESS;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                HELD, LONG_HELD: begin
                    if (!sync2) begin
                        // A single stable sample is already enough to release.
                        if (STABLE_TICKS == 1) begin
                            state_nxt      = IDLE_UP;
                            cnt_nxt        = '0;
                            long_fired_nxt = 1'b0;
                            emit           = 1'b1;
                            emit_type      = RELEASE;
                        end else begin
                            state_nxt = DEB_UP;
                            cnt_nxt   = CW'(1);
                        end
                    end else if (state == HELD) begin
                        if (cnt_inc >= CW'(LONG_TICKS)) begin
                            state_nxt      = LONG_HELD;
                            cnt_nxt        = '0;
                            long_fired_nxt = 1'b1;
                            emit           = 1'b1;
                            emit_type      = LONG;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
                DEB_UP: begin
                    if (sync2) begin
                        // Bounce back up: long timer restarts unless LONG already fired.
                        state_nxt = long_fired ? LONG_HELD : HELD;
                        cnt_nxt   = '0;
                    end else if (cnt_inc >= CW'(STABLE_TICKS)) begin
                        state_nxt      = IDLE_UP;
                        cnt_nxt        = '0;
                        long_fired_nxt = 1'b0;
                        emit           = 1'b1;
                        emit_type      = RELEASE;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt      = IDLE_UP;
                    cnt_nxt        = '0;
                    long_fired_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE_UP;
            cnt        <= '0;
            long_fired <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            long_fired <= long_fired_nxt;
        end
    end

    // A slot being drained this cycle can take a new event without loss.
    assign ovf_set = emit && pend_vld && !drain;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld    <= 1'b0;
            pend_type_q <= NONE;
            ovf         <= 1'b0;
        end else begin
            if (emit && !ovf_set) begin
                pend_vld    <= 1'b1;
                pend_type_q <= emit_type;
            end else if (drain) begin
                pend_vld <= 1'b0;
            end
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    assign pend_type = pend_type_q;
    assign level     = (state == HELD) || (state == LONG_HELD) || (state == DEB_UP);

endmodule

// File: rtl/btn_event_ctrl.sv
// Multi-button event controller: shared sample tick, NUM_BTN debounce
// channels and a round-robin arbiter feeding one registered valid/ready stream.
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int  NUM_BTN      = 4,
    parameter int  TICK_DIV     = 250_000,
    parameter int  STABLE_TICKS = 10,
    parameter int  LONG_TICKS   = 400,
    localparam int BW           = clog2_min1(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [BW-1:0]      evt_btn,
    output logic [1:0]         evt_type,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] ovf,
    input  logic [NUM_BTN-1:0] ovf_clr
);

    localparam int DW = clog2_min1(TICK_DIV);

    logic [DW-1:0]             div_cnt;
    logic                      tick;
    logic [NUM_BTN-1:0]        pend_vld, grant;
    logic [NUM_BTN-1:0][1:0]   pend_type;
    logic [BW-1:0]             rr_ptr, win;
    logic                      load_en, found;

    assign tick = (div_cnt == DW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (btn_raw[g]),
            .tick      (tick),
            .drain     (grant[g]),
            .ovf_clr   (ovf_clr[g]),
            .pend_vld  (pend_vld[g]),
            .pend_type (pend_type[g]),
            .level     (btn_level[g]),
            .ovf       (ovf[g])
        );
    end

    // First pending channel at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        win     = '0;
        grant   = '0;
        load_en = !evt_valid || evt_ready;
        for (int i = 0; i < NUM_BTN; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_BTN;
            if (!found && pend_vld[idx]) begin
                found = 1'b1;
                win   = BW'(idx);
            end
        end
        if (load_en && found)
            grant[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_btn   <= '0;
            evt_type  <= 2'd0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            evt_valid <= found;
            if (found) begin
                evt_btn  <= win;
                evt_type <= pend_type[win];
                rr_ptr   <= (win == BW'(NUM_BTN - 1)) ? '0 : win + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl: directed scenarios plus randomized
// traffic checked against a behavioural run-length debounce/arbiter model.
module tb_btn_event_ctrl;

    localparam int NB = 4;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int LT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_btn;
    logic [1:0]    evt_type;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] ovf;
    logic [NB-1:0] ovf_clr;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model state
    int            m_div;
    logic [NB-1:0] m_sy1, m_sy2, m_lvl, m_longd, m_pv, m_ovf;
    int            m_run  [NB];
    int            m_hold [NB];
    logic [1:0]    m_pt   [NB];
    logic          m_ov;
    logic [1:0]    m_ob, m_ot;
    int            m_rr;

    typedef struct {
        int btn;
        int typ;
        int cyc;
    } ev_t;
    ev_t evlog[$];

    btn_event_ctrl #(
        .NUM_BTN      (NB),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .LONG_TICKS   (LT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_btn   (evt_btn),
        .evt_type  (evt_type),
        .btn_level (btn_level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Debounce viewed as: debounced level, run of opposite samples, ticks held.
    task automatic model_step();
        bit         tick, load, found, drain, set;
        int         win;
        logic [NB-1:0] emit;
        logic [1:0] et [NB];
        if (rst) begin
            m_div = 0; m_sy1 = '0; m_sy2 = '0; m_lvl = '0; m_longd = '0;
            m_pv = '0; m_ovf = '0; m_ov = 1'b0; m_ob = '0; m_ot = '0; m_rr = 0;
            for (int c = 0; c < NB; c++) begin
                m_run[c] = 0; m_hold[c] = 0; m_pt[c] = '0;
            end
            return;
        end
        tick = (m_div == TD - 1);
        emit = '0;
        for (int c = 0; c < NB; c++) begin
            et[c] = 2'd0;
            if (tick) begin
                if (m_sy2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == ST) begin
                        m_run[c] = 0;
                        m_lvl[c] = m_sy2[c];
                        emit[c]  = 1'b1;
                        if (m_lvl[c]) begin
                            et[c] = 2'd1; m_hold[c] = 0;
                        end else begin
                            et[c] = 2'd2; m_longd[c] = 1'b0;
                        end
                    end
                end else if (m_run[c] != 0) begin
                    m_run[c] = 0;
                    if (m_lvl[c]) m_hold[c] = 0;
                end else if (m_lvl[c] && !m_longd[c]) begin
                    m_hold[c]++;
                    if (m_hold[c] == LT) begin
                        m_longd[c] = 1'b1; emit[c] = 1'b1; et[c] = 2'd3;
                    end
                end
            end
        end
        load  = !m_ov || evt_ready;
        found = 1'b0;
        win   = 0;
        for (int i = 0; i < NB; i++)
            if (!found && m_pv[(m_rr + i) % NB]) begin
                found = 1'b1; win = (m_rr + i) % NB;
            end
        if (load) begin
            m_ov = found;
            if (found) begin
                m_ob = 2'(win); m_ot = m_pt[win]; m_rr = (win + 1) % NB;
            end
        end
        for (int c = 0; c < NB; c++) begin
            drain = load && found && (win == c);
            set   = emit[c] && m_pv[c] && !drain;
            if (set) m_ovf[c] = 1'b1;
            else if (ovf_clr[c]) m_ovf[c] = 1'b0;
            if (emit[c] && !set) begin
                m_pv[c] = 1'b1; m_pt[c] = et[c];
            end else if (drain) begin
                m_pv[c] = 1'b0;
            end
        end
        m_sy2 = m_sy1;
        m_sy1 = btn_raw;
        m_div = tick ? 0 : m_div + 1;
    endtask

    task automatic cycle();
        ev_t e;
        if (!rst && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            e.btn = int'(evt_btn); e.typ = int'(evt_type); e.cyc = cyc;
            evlog.push_back(e);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_raw = '0; evt_ready = 1'b0; ovf_clr = '0;
        repeat (3) cycle();
        n_total++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", evt_valid); else n_pass++;
        n_total++; if (evt_btn !== 2'd0) $display("FAIL reset_btn: got %0d expected 0", evt_btn); else n_pass++;
        n_total++; if (evt_type !== 2'd0) $display("FAIL reset_type: got %0d expected 0", evt_type); else n_pass++;
        n_total++; if (btn_level !== 4'b0) $display("FAIL reset_level: got %b expected 0000", btn_level); else n_pass++;
        n_total++; if (ovf !== 4'b0) $display("FAIL reset_ovf: got %b expected 0000", ovf); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        int exp_t [3] = '{1, 3, 2};
        evlog.delete(); evt_ready = 1'b1;
        btn_raw[2] = 1'b1;
        repeat (20 * TD) cycle();
        n_total++; if (btn_level !== 4'b0100) $display("FAIL press_level_held: got %b expected 0100", btn_level); else n_pass++;
        btn_raw[2] = 1'b0;
        repeat (10 * TD) cycle();
        n_total++; if (btn_level !== 4'b0000) $display("FAIL press_level_rel: got %b expected 0000", btn_level); else n_pass++;
        n_total++; if (evlog.size() != 3) $display("FAIL press_count: got %0d expected 3", evlog.size()); else n_pass++;
        for (int k = 0; k < evlog.size() && k < 3; k++) begin
            n_total++;
            if (evlog[k].btn != 2 || evlog[k].typ != exp_t[k])
                $display("FAIL press_evt%0d: got btn %0d type %0d expected btn 2 type %0d", k, evlog[k].btn, evlog[k].typ, exp_t[k]);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        bit lvl_seen = 1'b0;
        evlog.delete(); evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            btn_raw[0] = (k % 2 == 0);
            repeat (5) begin
                cycle();
                if (btn_level !== 4'b0) lvl_seen = 1'b1;
            end
        end
        btn_raw[0] = 1'b0;
        repeat (40) begin
            cycle();
            if (btn_level !== 4'b0) lvl_seen = 1'b1;
        end
        n_total++; if (evlog.size() != 0) $display("FAIL bounce_events: got %0d expected 0", evlog.size()); else n_pass++;
        n_total++; if (lvl_seen !== 1'b0) $display("FAIL bounce_level: got level high expected 0"); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ord [4] = '{2, 3, 0, 1};
        apply_reset(); evlog.delete(); evt_ready = 1'b1;
        btn_raw = 4'hF; repeat (6 * TD) cycle();
        btn_raw = 4'h0; repeat (8 * TD) cycle();
        n_total++; if (evlog.size() != 8) $display("FAIL rr_count: got %0d expected 8", evlog.size()); else n_pass++;
        for (int k = 0; k < evlog.size() && k < 8; k++) begin
            n_total++;
            if (evlog[k].btn != k % 4 || evlog[k].typ != ((k < 4) ? 1 : 2))
                $display("FAIL rr_order%0d: got btn %0d type %0d expected btn %0d type %0d", k, evlog[k].btn, evlog[k].typ, k % 4, (k < 4) ? 1 : 2);
            else n_pass++;
        end
        for (int k = 1; k < evlog.size() && k < 4; k++) begin
            n_total++;
            if (evlog[k].cyc != evlog[k-1].cyc + 1)
                $display("FAIL rr_gap%0d: got %0d cycles expected 1", k, evlog[k].cyc - evlog[k-1].cyc);
            else n_pass++;
        end
        evlog.delete();
        btn_raw[1] = 1'b1; repeat (6 * TD) cycle();
        btn_raw[1] = 1'b0; repeat (8 * TD) cycle();
        n_total++; if (evlog.size() != 2) $display("FAIL rr_single: got %0d expected 2", evlog.size()); else n_pass++;
        evlog.delete();
        btn_raw = 4'hF; repeat (6 * TD) cycle();
        n_total++; if (evlog.size() != 4) $display("FAIL rr2_count: got %0d expected 4", evlog.size()); else n_pass++;
        for (int k = 0; k < evlog.size() && k < 4; k++) begin
            n_total++;
            if (evlog[k].btn != ord[k] || evlog[k].typ != 1)
                $display("FAIL rr2_order%0d: got btn %0d type %0d expected btn %0d type 1", k, evlog[k].btn, evlog[k].typ, ord[k]);
            else n_pass++;
        end
        btn_raw = 4'h0; repeat (8 * TD) cycle();
    endtask

    task automatic test_overflow();
        bit unstable = 1'b0;
        apply_reset(); evlog.delete(); evt_ready = 1'b0;
        btn_raw[1] = 1'b1;
        repeat (15 * TD) begin
            cycle();
            if (evt_valid === 1'b1 && (evt_btn !== 2'd1 || evt_type !== 2'd1)) unstable = 1'b1;
        end
        btn_raw[1] = 1'b0;
        repeat (85 * TD) begin
            cycle();
            if (evt_valid === 1'b1 && (evt_btn !== 2'd1 || evt_type !== 2'd1)) unstable = 1'b1;
        end
        n_total++; if (unstable !== 1'b0) $display("FAIL ovf_hold: got output change expected stable PRESS(1)"); else n_pass++;
        n_total++;
        if (evt_valid !== 1'b1 || evt_btn !== 2'd1 || evt_type !== 2'd1)
            $display("FAIL ovf_present: got v%b btn %0d type %0d expected v1 btn 1 type 1", evt_valid, evt_btn, evt_type);
        else n_pass++;
        n_total++; if (ovf !== 4'b0010) $display("FAIL ovf_set: got %b expected 0010", ovf); else n_pass++;
        ovf_clr[1] = 1'b1; cycle(); ovf_clr = '0;
        n_total++; if (ovf !== 4'b0000) $display("FAIL ovf_clr: got %b expected 0000", ovf); else n_pass++;
        evt_ready = 1'b1; repeat (8) cycle();
        n_total++;
        if (evlog.size() != 2 || evlog[0].typ != 1 || evlog[1].typ != 3 || evlog[0].btn != 1 || evlog[1].btn != 1)
            $display("FAIL ovf_drain: got %0d events expected PRESS(1) LONG(1)", evlog.size());
        else n_pass++;
    endtask

    task automatic test_glitch();
        bit dropped = 1'b0;
        evlog.delete(); evt_ready = 1'b1;
        btn_raw[3] = 1'b1; repeat (15 * TD) cycle();
        btn_raw[3] = 1'b0; repeat (TD) cycle();
        btn_raw[3] = 1'b1;
        repeat (12 * TD) begin
            cycle();
            if (btn_level[3] !== 1'b1) dropped = 1'b1;
        end
        n_total++; if (dropped !== 1'b0) $display("FAIL glitch_level: got level low expected held"); else n_pass++;
        n_total++;
        if (evlog.size() != 2 || evlog[0].typ != 1 || evlog[1].typ != 3 || evlog[1].btn != 3)
            $display("FAIL glitch_events: got %0d events expected PRESS(3) LONG(3)", evlog.size());
        else n_pass++;
        btn_raw[3] = 1'b0; repeat (8 * TD) cycle();
        n_total++;
        if (evlog.size() != 3 || evlog[2].typ != 2 || evlog[2].btn != 3)
            $display("FAIL glitch_release: got %0d events expected RELEASE(3) last", evlog.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        evlog.delete(); evt_ready = 1'b0; btn_raw = '0;
        btn_raw[2] = 1'b1; repeat (6 * TD) cycle();
        btn_raw[0] = 1'b1; repeat (6) cycle();
        n_total++; if (evt_valid !== 1'b1) $display("FAIL rstmid_pre: got valid %b expected 1", evt_valid); else n_pass++;
        rst = 1'b1; cycle();
        n_total++;
        if (evt_valid !== 1'b0 || evt_btn !== 2'd0 || evt_type !== 2'd0 || btn_level !== 4'b0 || ovf !== 4'b0)
            $display("FAIL rstmid_out: got v%b btn %0d type %0d lvl %b ovf %b expected all 0", evt_valid, evt_btn, evt_type, btn_level, ovf);
        else n_pass++;
        rst = 1'b0; btn_raw = '0; evt_ready = 1'b1;
        repeat (10 * TD) cycle();
        n_total++; if (evlog.size() != 0) $display("FAIL rstmid_stale: got %0d events expected 0", evlog.size()); else n_pass++;
    endtask

    task automatic test_random();
        int idx;
        apply_reset(); evt_ready = 1'b1;
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                idx = int'($urandom_range(0, NB - 1));
                btn_raw[idx] = ~btn_raw[idx];
            end
            if ($urandom_range(0, 7) == 0) evt_ready = ~evt_ready;
            ovf_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
            cycle();
            n_total++;
            if (evt_valid !== m_ov || evt_btn !== m_ob || evt_type !== m_ot || btn_level !== m_lvl || ovf !== m_ovf)
                $display("FAIL random cyc %0d: got v%b btn %0d type %0d lvl %b ovf %b expected v%b btn %0d type %0d lvl %b ovf %b",
                         cyc, evt_valid, evt_btn, evt_type, btn_level, ovf, m_ov, m_ob, m_ot, m_lvl, m_ovf);
            else n_pass++;
        end
        ovf_clr = '0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_back_to_back();
        test_overflow();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
